// File: rtl/frame_buffer.sv
// Double-buffered 128x64 monochrome frame store feeding the LCD driver.
// Drawing targets the back bank; commit swaps banks and pulses start_o without tearing a scan.
module frame_buffer #(
    parameter int SCAN_CYCLES = 2200,
    parameter int START_LEN   = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    input  logic [9:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic       wr_or_i,
    input  logic       clear_i,
    input  logic       commit_i,
    output logic       busy_o,
    input  logic [9:0] rd_addr_i,
    output logic [7:0] rd_data_o,
    output logic       start_o
);

    localparam int HW = $clog2(SCAN_CYCLES + 1);
    localparam int SW = (START_LEN > 1) ? $clog2(START_LEN) : 1;
    localparam logic [HW-1:0] HOLDOFF_INIT = HW'(SCAN_CYCLES);
    localparam logic [SW-1:0] ST_INIT      = SW'(START_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RMW   = 3'd2,
        S_WAIT  = 3'd3,
        S_START = 3'd4
    } state_t;

    logic [7:0]    r_mem [0:2047];

    state_t        r_state;
    logic          r_front_sel;
    logic          r_start;
    logic          r_busy;
    logic [7:0]    r_rd_data;
    logic [9:0]    r_clr_cnt;
    logic [SW-1:0] r_st_cnt;
    logic [HW-1:0] r_holdoff;
    logic [9:0]    r_rmw_addr;
    logic [7:0]    r_rmw_data;
    logic [7:0]    r_rmw_old;

    state_t        w_state_nx;
    logic          w_front_sel_nx;
    logic          w_start_nx;
    logic [9:0]    w_clr_cnt_nx;
    logic [SW-1:0] w_st_cnt_nx;
    logic [HW-1:0] w_holdoff_nx;
    logic [9:0]    w_rmw_addr_nx;
    logic [7:0]    w_rmw_data_nx;
    logic          w_mem_we;
    logic [10:0]   w_mem_waddr;
    logic [7:0]    w_mem_wdata;
    logic          w_idle;

    assign w_idle     = (r_state == S_IDLE);
    // Ready is combinational on clear/commit so a losing write is visibly refused.
    assign wr_ready_o = w_idle && !clear_i && !commit_i;
    assign busy_o     = r_busy;
    assign rd_data_o  = r_rd_data;
    assign start_o    = r_start;

    // Next-state, counter and memory write-port decode.
    always_comb begin
        w_state_nx     = r_state;
        w_front_sel_nx = r_front_sel;
        w_start_nx     = r_start;
        w_clr_cnt_nx   = r_clr_cnt;
        w_st_cnt_nx    = r_st_cnt;
        w_rmw_addr_nx  = r_rmw_addr;
        w_rmw_data_nx  = r_rmw_data;
        w_mem_we       = 1'b0;
        w_mem_waddr    = 11'd0;
        w_mem_wdata    = 8'd0;
        if (r_holdoff != '0) begin
            w_holdoff_nx = r_holdoff - HW'(1);
        end else begin
            w_holdoff_nx = r_holdoff;
        end

        case (r_state)
            S_IDLE: begin
                if (clear_i) begin
                    w_clr_cnt_nx = 10'd0;
                    w_state_nx   = S_CLEAR;
                end else if (commit_i) begin
                    w_state_nx = S_WAIT;
                end else if (wr_valid_i) begin
                    if (wr_or_i) begin
                        w_rmw_addr_nx = wr_addr_i;
                        w_rmw_data_nx = wr_data_i;
                        w_state_nx    = S_RMW;
                    end else begin
                        w_mem_we    = 1'b1;
                        w_mem_waddr = {~r_front_sel, wr_addr_i};
                        w_mem_wdata = wr_data_i;
                    end
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_CLEAR: begin
                w_mem_we     = 1'b1;
                w_mem_waddr  = {~r_front_sel, r_clr_cnt};
                w_mem_wdata  = 8'd0;
                w_clr_cnt_nx = r_clr_cnt + 10'd1;
                if (r_clr_cnt == 10'd1023) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_CLEAR;
                end
            end
            S_RMW: begin
                w_mem_we    = 1'b1;
                w_mem_waddr = {~r_front_sel, r_rmw_addr};
                w_mem_wdata = r_rmw_old | r_rmw_data;
                w_state_nx  = S_IDLE;
            end
            S_WAIT: begin
                // Swap only once the previous scan window has fully elapsed.
                if (r_holdoff == '0) begin
                    w_front_sel_nx = ~r_front_sel;
                    w_start_nx     = 1'b1;
                    w_st_cnt_nx    = ST_INIT;
                    w_state_nx     = S_START;
                end else begin
                    w_state_nx = S_WAIT;
                end
            end
            S_START: begin
                if (r_st_cnt == '0) begin
                    w_start_nx   = 1'b0;
                    w_holdoff_nx = HOLDOFF_INIT;
                    w_state_nx   = S_IDLE;
                end else begin
                    w_st_cnt_nx = r_st_cnt - SW'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_front_sel <= 1'b0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_data   <= 8'd0;
            r_clr_cnt   <= 10'd0;
            r_st_cnt    <= '0;
            r_holdoff   <= '0;
            r_rmw_addr  <= 10'd0;
            r_rmw_data  <= 8'd0;
        end else begin
            r_state     <= w_state_nx;
            r_front_sel <= w_front_sel_nx;
            r_start     <= w_start_nx;
            r_busy      <= (w_state_nx != S_IDLE);
            r_rd_data   <= r_mem[{r_front_sel, rd_addr_i}];
            r_clr_cnt   <= w_clr_cnt_nx;
            r_st_cnt    <= w_st_cnt_nx;
            r_holdoff   <= w_holdoff_nx;
            r_rmw_addr  <= w_rmw_addr_nx;
            r_rmw_data  <= w_rmw_data_nx;
        end
    end

    // Frame storage (never reset) and the read half of the OR-merge.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
        r_rmw_old <= r_mem[{~r_front_sel, wr_addr_i}];
    end

endmodule

// File: tb/tb_frame_buffer.sv
// Randomized scoreboard bench for frame_buffer: a bank-level model predicts read data,
// swap timing and busy windows from the block's rules.
module tb_frame_buffer;

    localparam int SCAN = 2200;
    localparam int SLEN = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       wr_valid_i = 1'b0;
    logic       wr_ready_o;
    logic [9:0] wr_addr_i = 10'd0;
    logic [7:0] wr_data_i = 8'd0;
    logic       wr_or_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       commit_i = 1'b0;
    logic       busy_o;
    logic [9:0] rd_addr_i = 10'd0;
    logic [7:0] rd_data_o;
    logic       start_o;

    frame_buffer #(.SCAN_CYCLES(SCAN), .START_LEN(SLEN)) dut (
        .clk(clk), .rstn(rstn),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_or_i(wr_or_i),
        .clear_i(clear_i), .commit_i(commit_i), .busy_o(busy_o),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .start_o(start_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp;
        bit         chk;
    } rd_exp_t;

    rd_exp_t    rq[$];
    logic [7:0] m_data [0:2047];
    bit         m_known [0:2047];
    bit         m_front = 1'b0;
    int         last_fall = -1;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    bit         rd_en = 1'b0;
    bit         rd_issued = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bidx(input bit bank, input logic [9:0] a);
        return int'({bank, a});
    endfunction

    // Monitor: a read issued before a rising edge is compared at the following falling edge.
    always @(posedge clk) rd_issued <= rd_en;

    always @(negedge clk) begin
        rd_exp_t e;
        if (rd_issued) begin
            if (rq.size() == 0) begin
                chk("rd_queue_underflow", 32'd0, 32'd1);
            end else begin
                e = rq.pop_front();
                if (e.chk) chk("rd_data", {24'd0, rd_data_o}, {24'd0, e.exp});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic issue_read(input logic [9:0] a);
        rd_exp_t e;
        rd_addr_i = a;
        rd_en     = 1'b1;
        e.exp = m_data[bidx(m_front, a)];
        e.chk = m_known[bidx(m_front, a)];
        rq.push_back(e);
    endtask

    task automatic issue_const(input logic [9:0] a, input logic [7:0] v);
        rd_exp_t e;
        rd_addr_i = a;
        rd_en     = 1'b1;
        e.exp = v;
        e.chk = 1'b1;
        rq.push_back(e);
    endtask

    task automatic read_all();
        for (int i = 0; i < 1024; i++) begin
            tick();
            issue_read(10'(i));
        end
        tick();
    endtask

    task automatic wr_op(input logic [9:0] a, input logic [7:0] d, input bit o);
        int idx;
        tick();
        wr_valid_i = 1'b1;
        wr_addr_i  = a;
        wr_data_i  = d;
        wr_or_i    = o;
        #1 chk("wr_ready_idle", {31'd0, wr_ready_o}, 32'd1);
        idx = bidx(~m_front, a);
        if (o) begin
            m_data[idx] = m_data[idx] | d;
        end else begin
            m_data[idx]  = d;
            m_known[idx] = 1'b1;
        end
        tick();
        wr_valid_i = 1'b0;
        wr_or_i    = 1'b0;
        if (o) begin
            #1 chk("wr_ready_rmw", {31'd0, wr_ready_o}, 32'd0);
            tick();
            #1 chk("wr_ready_after_rmw", {31'd0, wr_ready_o}, 32'd1);
        end
    endtask

    task automatic do_clear(input bit combo, input bit rd_during);
        int n;
        int starts;
        tick();
        clear_i = 1'b1;
        if (combo) begin
            commit_i   = 1'b1;
            wr_valid_i = 1'b1;
            wr_addr_i  = 10'($urandom_range(0, 1023));
            wr_data_i  = 8'hFF;
            wr_or_i    = 1'b0;
        end
        #1 chk("ready_during_clear_req", {31'd0, wr_ready_o}, 32'd0);
        tick();
        clear_i    = 1'b0;
        commit_i   = 1'b0;
        wr_valid_i = 1'b0;
        n = 0;
        starts = 0;
        while (busy_o && n < 3000) begin
            n++;
            if (start_o) starts++;
            if (rd_during) issue_read(10'($urandom_range(0, 1023)));
            tick();
        end
        chk("clear_busy_cycles", n, 1024);
        chk("clear_no_start", starts, 0);
        for (int i = 0; i < 1024; i++) begin
            m_data[bidx(~m_front, 10'(i))]  = 8'd0;
            m_known[bidx(~m_front, 10'(i))] = 1'b1;
        end
    endtask

    task automatic do_commit();
        int n;
        int hi;
        int ec;
        int exp_rise;
        tick();
        commit_i = 1'b1;
        ec = cyc + 1;
        #1 chk("ready_during_commit", {31'd0, wr_ready_o}, 32'd0);
        tick();
        commit_i = 1'b0;
        chk("busy_after_commit", {31'd0, busy_o}, 32'd1);
        if (last_fall < 0) exp_rise = ec + 1;
        else exp_rise = ((ec > last_fall + SCAN) ? ec : last_fall + SCAN) + 1;
        n = 0;
        while (!start_o && n < 6000) begin
            tick();
            n++;
        end
        chk("start_rise", {31'd0, start_o}, 32'd1);
        chk("start_rise_cycle", cyc, exp_rise);
        hi = 0;
        while (start_o && hi < 20) begin
            hi++;
            tick();
        end
        chk("start_len", hi, SLEN);
        chk("idle_after_start", {31'd0, busy_o}, 32'd0);
        last_fall = cyc;
        m_front = ~m_front;
    endtask

    initial begin
        int r;
        int e0;
        for (int i = 0; i < 2048; i++) begin
            m_data[i]  = 8'd0;
            m_known[i] = 1'b0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd_data", {24'd0, rd_data_o}, 32'd0);
        chk("rst_ready", {31'd0, wr_ready_o}, 32'd1);
        chk("rst_start", {31'd0, start_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Clear, first commit without wait, stalled second commit, then both banks zeroed
        do_clear(1'b0, 1'b0);
        do_commit();
        repeat (10) tick();
        do_commit();
        do_commit();
        do_clear(1'b0, 1'b1);
        read_all();
        do_commit();
        read_all();

        // Overwrite then OR-merge at one address
        wr_op(10'h215, 8'h3C, 1'b0);
        wr_op(10'h215, 8'h81, 1'b1);
        do_commit();
        tick();
        issue_const(10'h215, 8'hBD);
        tick();
        read_all();

        // Randomized drawing, reads and swaps
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 29);
            if (r < 14) begin
                wr_op(10'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)), 1'b0);
            end else if (r < 22) begin
                wr_op(10'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)), 1'b1);
            end else if (r < 29) begin
                for (int j = 0; j < 8; j++) begin
                    tick();
                    issue_read(10'($urandom_range(0, 1023)));
                end
                tick();
            end else begin
                do_commit();
            end
        end

        // Simultaneous clear, commit and write: only the clear may run
        do_clear(1'b1, 1'b1);
        for (int j = 0; j < 16; j++) begin
            tick();
            issue_read(10'($urandom_range(0, 1023)));
        end
        tick();
        do_commit();
        read_all();

        // Asynchronous reset midway through a clear of bank 0
        if (!m_front) do_commit();
        tick();
        clear_i = 1'b1;
        e0 = cyc + 1;
        tick();
        clear_i = 1'b0;
        while (cyc < e0 + 500) tick();
        chk("busy_mid_clear", {31'd0, busy_o}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_start", {31'd0, start_o}, 32'd0);
        chk("arst_rd_data", {24'd0, rd_data_o}, 32'd0);
        chk("arst_ready", {31'd0, wr_ready_o}, 32'd1);
        for (int i = 0; i < 500; i++) begin
            m_data[bidx(~m_front, 10'(i))]  = 8'd0;
            m_known[bidx(~m_front, 10'(i))] = 1'b1;
        end
        m_front   = 1'b0;
        last_fall = -1;
        tick();
        tick();
        rstn = 1'b1;
        read_all();
        do_clear(1'b0, 1'b1);
        do_commit();
        read_all();

        repeat (3) tick();
        chk("scoreboard_drained", rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
